// File: rtl/demux_pkg.sv
// Shared types and constants for the 1-to-8 demux stage and its upstream scan controller.
package demux_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    FIN
  } state_t;

  localparam int DEMUX_CHANNELS = 8;

  // Width needed to index n items; a single item still needs one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/demux_scan_ctrl_hold_counter.sv
// Dwell counter: counts 0..TERMINAL-1 while enabled and flags the last cycle of each dwell.
module hold_counter
  import demux_pkg::*;
#(
  parameter int TERMINAL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int CNT_W = sel_width(TERMINAL);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TERMINAL - 1);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  assign tc = enable && (count == LAST);

endmodule

// File: rtl/demux_scan_ctrl.sv
// Serialises a parallel word onto the demux data line, stepping the channel select with a fixed dwell.
module demux_scan_ctrl
  import demux_pkg::*;
#(
  parameter  int CHANNELS    = DEMUX_CHANNELS,
  parameter  int HOLD_CYCLES = 4,
  localparam int SEL_W       = sel_width(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] dato_in,
  input  logic                valido_in,
  output logic                listo_out,
  input  logic                abortar,
  output logic                entrada_out,
  output logic [SEL_W-1:0]    sel_out,
  output logic                activo_out,
  output logic                fin_out
);

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(CHANNELS - 1);

  state_t              state;
  logic [CHANNELS-1:0] word;
  logic                hold_tc;

  hold_counter #(
    .TERMINAL(HOLD_CYCLES)
  ) u_hold (
    .clk   (clk),
    .rst   (rst),
    .clear (abortar || (state != SCAN)),
    .enable(state == SCAN),
    .tc    (hold_tc)
  );

  // NOTE: every branch assigns only registers inside always_ff, so no latch can be inferred.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      listo_out   <= 1'b1;
      entrada_out <= 1'b0;
      sel_out     <= '0;
      activo_out  <= 1'b0;
      fin_out     <= 1'b0;
      word        <= '0;
    end else if (abortar) begin
      // Abort drops the scan silently; the stale word is never presented again.
      state       <= IDLE;
      listo_out   <= 1'b1;
      entrada_out <= 1'b0;
      sel_out     <= '0;
      activo_out  <= 1'b0;
      fin_out     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (valido_in) begin
            word        <= dato_in;
            state       <= SCAN;
            sel_out     <= '0;
            entrada_out <= dato_in[0];
            activo_out  <= 1'b1;
            listo_out   <= 1'b0;
          end
        end
        SCAN: begin
          if (hold_tc) begin
            if (sel_out == LAST_SEL) begin
              state       <= FIN;
              activo_out  <= 1'b0;
              sel_out     <= '0;
              entrada_out <= 1'b0;
              fin_out     <= 1'b1;
            end else begin
              sel_out     <= sel_out + 1'b1;
              entrada_out <= word[sel_out + 1'b1];
            end
          end
        end
        FIN: begin
          fin_out   <= 1'b0;
          listo_out <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_demux_scan_ctrl.sv
// Directed bench for demux_scan_ctrl: one instance with a 4-cycle dwell, one with a 1-cycle dwell.
module tb_demux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       abortar;
  logic [7:0] dato;
  logic       valido;
  logic       listo, entrada, activo, fin;
  logic [2:0] sel;

  logic [7:0] h1_dato;
  logic       h1_valido;
  logic       h1_listo, h1_entrada, h1_activo, h1_fin;
  logic [2:0] h1_sel;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  demux_scan_ctrl #(.CHANNELS(8), .HOLD_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .dato_in(dato), .valido_in(valido), .listo_out(listo),
    .abortar(abortar), .entrada_out(entrada), .sel_out(sel), .activo_out(activo),
    .fin_out(fin)
  );

  demux_scan_ctrl #(.CHANNELS(8), .HOLD_CYCLES(1)) dut_h1 (
    .clk(clk), .rst(rst), .dato_in(h1_dato), .valido_in(h1_valido), .listo_out(h1_listo),
    .abortar(1'b0), .entrada_out(h1_entrada), .sel_out(h1_sel), .activo_out(h1_activo),
    .fin_out(h1_fin)
  );

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock; samples and drives happen 1 time unit after the rising edge.
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".listo"}, {7'd0, listo}, 8'd1);
    check({tag, ".activo"}, {7'd0, activo}, 8'd0);
    check({tag, ".sel"}, {5'd0, sel}, 8'd0);
    check({tag, ".entrada"}, {7'd0, entrada}, 8'd0);
    check({tag, ".fin"}, {7'd0, fin}, 8'd0);
  endtask

  logic [7:0] word;
  int         fin_cnt;
  logic       ent_seen;

  initial begin
    rst = 1'b1; abortar = 1'b0; dato = '0; valido = 1'b0;
    h1_dato = '0; h1_valido = 1'b0;

    // Reset from power-up / idle.
    tick(2);
    check_idle("reset_idle");
    rst = 1'b0;
    tick();

    // Single word 0xA5, 4-cycle dwell.
    word = 8'hA5;
    dato = word; valido = 1'b1;
    tick();
    valido = 1'b0; dato = 8'h00;
    check("a5.listo_busy", {7'd0, listo}, 8'd0);
    for (int ch = 0; ch < 8; ch++) begin
      for (int k = 0; k < 4; k++) begin
        check($sformatf("a5.sel_ch%0d_k%0d", ch, k), {5'd0, sel}, 8'(ch));
        check($sformatf("a5.bit_ch%0d_k%0d", ch, k), {7'd0, entrada}, {7'd0, word[ch]});
        check($sformatf("a5.act_ch%0d_k%0d", ch, k), {7'd0, activo}, 8'd1);
        check($sformatf("a5.fin_ch%0d_k%0d", ch, k), {7'd0, fin}, 8'd0);
        tick();
      end
    end
    check("a5.fin_pulse", {7'd0, fin}, 8'd1);
    check("a5.fin_activo", {7'd0, activo}, 8'd0);
    check("a5.fin_listo", {7'd0, listo}, 8'd0);
    check("a5.fin_sel", {5'd0, sel}, 8'd0);
    tick();
    check_idle("a5.after_fin");

    // Reset asserted mid-scan.
    dato = 8'hFF; valido = 1'b1;
    tick();
    valido = 1'b0;
    tick(6);
    check("midscan.activo_before", {7'd0, activo}, 8'd1);
    rst = 1'b1;
    tick(2);
    check_idle("reset_midscan");
    rst = 1'b0;
    tick();

    // Busy: valido with 0xFF during a scan of 0x00 must be ignored.
    dato = 8'h00; valido = 1'b1;
    tick();
    valido = 1'b0;
    fin_cnt = 0; ent_seen = 1'b0;
    for (int i = 0; i < 34; i++) begin
      if (i == 5) begin dato = 8'hFF; valido = 1'b1; end
      if (i == 8) begin valido = 1'b0; dato = 8'h00; end
      ent_seen = ent_seen | entrada;
      fin_cnt += int'(fin);
      tick();
    end
    check("busy.entrada_zero", {7'd0, ent_seen}, 8'd0);
    check("busy.fin_count", 8'(fin_cnt), 8'd1);
    check_idle("busy.end");

    // Abort while channel 3 is selected.
    dato = 8'hFF; valido = 1'b1;
    tick();
    valido = 1'b0;
    tick(13);
    check("abort.sel_before", {5'd0, sel}, 8'd3);
    abortar = 1'b1;
    tick();
    abortar = 1'b0;
    check_idle("abort.after");
    fin_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      fin_cnt += int'(fin);
      tick();
    end
    check("abort.no_fin", 8'(fin_cnt), 8'd0);

    // Following word 0x0F scans from channel 0.
    dato = 8'h0F; valido = 1'b1;
    tick();
    valido = 1'b0;
    check("w0f.sel0", {5'd0, sel}, 8'd0);
    check("w0f.bit0", {7'd0, entrada}, 8'd1);
    tick(4);
    check("w0f.sel1", {5'd0, sel}, 8'd1);
    check("w0f.bit1", {7'd0, entrada}, 8'd1);
    tick(12);
    check("w0f.sel4", {5'd0, sel}, 8'd4);
    check("w0f.bit4", {7'd0, entrada}, 8'd0);
    tick(16);
    check("w0f.fin", {7'd0, fin}, 8'd1);
    tick();

    // Simultaneous abortar and valido in IDLE: abort wins.
    dato = 8'hFF; valido = 1'b1; abortar = 1'b1;
    tick();
    check_idle("abort_valid.1");
    tick();
    check_idle("abort_valid.2");
    valido = 1'b0; abortar = 1'b0;
    tick();

    // Back-to-back words with valido held high, 1-cycle dwell.
    h1_dato = 8'h81; h1_valido = 1'b1;
    tick();
    h1_dato = 8'h18;
    for (int w = 0; w < 2; w++) begin
      word = (w == 0) ? 8'h81 : 8'h18;
      for (int ch = 0; ch < 8; ch++) begin
        check($sformatf("b2b%0d.sel_ch%0d", w, ch), {5'd0, h1_sel}, 8'(ch));
        check($sformatf("b2b%0d.bit_ch%0d", w, ch), {7'd0, h1_entrada}, {7'd0, word[ch]});
        check($sformatf("b2b%0d.act_ch%0d", w, ch), {7'd0, h1_activo}, 8'd1);
        tick();
      end
      check($sformatf("b2b%0d.fin", w), {7'd0, h1_fin}, 8'd1);
      check($sformatf("b2b%0d.fin_activo", w), {7'd0, h1_activo}, 8'd0);
      check($sformatf("b2b%0d.fin_listo", w), {7'd0, h1_listo}, 8'd0);
      if (w == 1) h1_valido = 1'b0;
      tick();
      check($sformatf("b2b%0d.idle_listo", w), {7'd0, h1_listo}, 8'd1);
      check($sformatf("b2b%0d.idle_activo", w), {7'd0, h1_activo}, 8'd0);
      check($sformatf("b2b%0d.idle_fin", w), {7'd0, h1_fin}, 8'd0);
      if (w == 0) tick();
    end
    tick();
    check("b2b.no_third", {7'd0, h1_activo}, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
